// File: rtl/outbuff_drain_ctrl.sv
// Drain controller for the even/odd output buffer banks: sweeps an address range, reads both
// banks interleaved and streams row vectors over valid/ready. Optional macro: OUTDRAIN_RELU_EN.
module outbuff_drain_ctrl #(
  parameter int num_pe_row         = 16,
  parameter int data_width_to_buff = 16,
  parameter int nb_data            = 8192,
  parameter int addr_width         = $clog2(nb_data)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic [addr_width-1:0]                            base_addr,
  input  logic [addr_width:0]                              num_words,
  output logic                                             busy,
  output logic                                             done,
  output logic [num_pe_row-1:0]                            rEn_even_AH,
  output logic [num_pe_row-1:0]                            rEn_odd_AH,
  output logic [num_pe_row-1:0][addr_width-1:0]            rAddr_even,
  output logic [num_pe_row-1:0][addr_width-1:0]            rAddr_odd,
  input  logic [num_pe_row-1:0][data_width_to_buff-1:0]    buff_data_out_even,
  input  logic [num_pe_row-1:0][data_width_to_buff-1:0]    buff_data_out_odd,
  output logic [num_pe_row-1:0][data_width_to_buff-1:0]    out_data,
  output logic                                             out_is_odd,
  output logic                                             out_last,
  output logic                                             out_valid,
  input  logic                                             out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;
  typedef logic [num_pe_row-1:0][data_width_to_buff-1:0] row_t;
  typedef struct packed {
    logic odd;
    logic last;
    row_t data;
  } beat_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d, raddr_e_q, raddr_e_d, raddr_o_q, raddr_o_d;
  logic [addr_width:0]   cnt_q, cnt_d;
  logic                  bank_q, bank_d;
  logic                  fl_vld_q, fl_vld_d, fl_odd_q, fl_odd_d, fl_last_q, fl_last_d;
  beat_t                 fifo_q [2];
  beat_t                 fifo_d [2];
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            fcnt_q, fcnt_d;
  logic                  pop, issue, last_rd;
  logic [2:0]            occ;
  beat_t                 head;

  assign pop     = (fcnt_q != 2'd0) && out_ready;
  // Count the beat leaving this cycle so a steady ready stream keeps one read per cycle.
  assign occ     = {1'b0, fcnt_q} + {2'b00, fl_vld_q} - {2'b00, pop};
  assign issue   = (state_q == S_READ) && (occ < 3'd2);
  assign last_rd = bank_q && (cnt_q == (addr_width+1)'(1));
  assign head    = fifo_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      raddr_e_q <= '0;
      raddr_o_q <= '0;
      cnt_q     <= '0;
      bank_q    <= 1'b0;
      fl_vld_q  <= 1'b0;
      fl_odd_q  <= 1'b0;
      fl_last_q <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      raddr_e_q <= raddr_e_d;
      raddr_o_q <= raddr_o_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      fl_vld_q  <= fl_vld_d;
      fl_odd_q  <= fl_odd_d;
      fl_last_q <= fl_last_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_words == '0) ? S_DONE : S_READ;
      S_READ:  if (issue && last_rd) state_d = S_FLUSH;
      S_FLUSH: if (!fl_vld_q && (fcnt_q == 2'd0 || (fcnt_q == 2'd1 && pop))) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    raddr_e_d = raddr_e_q;
    raddr_o_d = raddr_o_q;
    fl_vld_d  = issue;
    fl_odd_d  = fl_odd_q;
    fl_last_d = fl_last_q;
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fcnt_d    = fcnt_q + {1'b0, fl_vld_q} - {1'b0, pop};
    if (state_q == S_IDLE && start && num_words != '0) begin
      addr_d = base_addr;
      cnt_d  = num_words;
      bank_d = 1'b0;
    end
    if (issue) begin
      fl_odd_d  = bank_q;
      fl_last_d = last_rd;
      bank_d    = ~bank_q;
      if (bank_q) begin
        raddr_o_d = addr_q;
        addr_d    = addr_q + addr_width'(1);
        cnt_d     = cnt_q - (addr_width+1)'(1);
      end else begin
        raddr_e_d = addr_q;
      end
    end
    // SRAM data arrives one cycle after its enable; capture it with the bank tag.
    if (fl_vld_q) begin
      fifo_d[wr_ptr_q].odd  = fl_odd_q;
      fifo_d[wr_ptr_q].last = fl_last_q;
      fifo_d[wr_ptr_q].data = fl_odd_q ? buff_data_out_odd : buff_data_out_even;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  always_comb begin
    busy        = (state_q == S_READ) || (state_q == S_FLUSH);
    done        = (state_q == S_DONE);
    rEn_even_AH = {num_pe_row{issue && !bank_q}};
    rEn_odd_AH  = {num_pe_row{issue && bank_q}};
    out_valid   = (fcnt_q != 2'd0);
    out_is_odd  = out_valid && head.odd;
    out_last    = out_valid && head.last;
    for (int r = 0; r < num_pe_row; r++) begin
      rAddr_even[r] = (issue && !bank_q) ? addr_q : raddr_e_q;
      rAddr_odd[r]  = (issue && bank_q) ? addr_q : raddr_o_q;
      out_data[r]   = '0;
      if (out_valid) begin
        out_data[r] = head.data[r];
`ifdef OUTDRAIN_RELU_EN
        if (head.data[r][data_width_to_buff-1]) out_data[r] = '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_outbuff_drain_ctrl.sv
// Directed bench for outbuff_drain_ctrl: ordering, wrap, backpressure, empty sweep, reset, clamp.
module tb_outbuff_drain_ctrl;
  localparam int NR = 16, DW = 16, AW = 13;
  typedef logic [NR-1:0][DW-1:0] row_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] num_words = '0;
  logic busy, done, out_is_odd, out_last, out_valid;
  logic [NR-1:0] rEn_even_AH, rEn_odd_AH;
  logic [NR-1:0][AW-1:0] rAddr_even, rAddr_odd;
  row_t buff_data_out_even, buff_data_out_odd, out_data;
  bit pat = 0;
  int total = 0, bad = 0;

  row_t bdata [64];
  bit bodd [64], blast [64], rodd [64];
  int bcyc [64], rcyc [64];
  logic [AW-1:0] raddr [64];
  int nb, nr, done_cyc, max_out, hold_err, en_err, stalls, valid_cnt;
  logic busy_at_done;

  outbuff_drain_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .rEn_even_AH(rEn_even_AH), .rEn_odd_AH(rEn_odd_AH),
    .rAddr_even(rAddr_even), .rAddr_odd(rAddr_odd),
    .buff_data_out_even(buff_data_out_even), .buff_data_out_odd(buff_data_out_odd),
    .out_data(out_data), .out_is_odd(out_is_odd), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  // Bank SRAMs: word encodes bank, low address bits and row; read latency one cycle.
  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) begin
      if (rEn_even_AH[r]) buff_data_out_even[r] <= pat ? 16'hFF00 : {1'b0, rAddr_even[r][10:0], 4'(r)};
      if (rEn_odd_AH[r])  buff_data_out_odd[r]  <= pat ? 16'h0100 : {1'b1, rAddr_odd[r][10:0], 4'(r)};
    end
  end

  function automatic row_t exp_vec(input bit odd, input logic [AW-1:0] a);
    row_t v;
    for (int r = 0; r < NR; r++) begin
      v[r] = {odd, a[10:0], 4'(r)};
`ifdef OUTDRAIN_RELU_EN
      if (v[r][DW-1]) v[r] = '0;
`endif
    end
    return v;
  endfunction

  // Drives one sweep and records reads/beats; the test tasks judge the records.
  task automatic run_sweep(input logic [AW-1:0] b, input logic [AW:0] n, input int mode,
                           input int stop_at, input bit poke);
    bit stall_prev;
    row_t sd;
    logic so, sl;
    nb = 0; nr = 0; done_cyc = -1; max_out = 0; hold_err = 0; en_err = 0; stalls = 0;
    valid_cnt = 0; busy_at_done = 1'b1; stall_prev = 0; sd = '0; so = 1'b0; sl = 1'b0;
    @(negedge clk);
    base_addr = b; num_words = n; start = 1'b1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      start = poke && (c == 4);
      base_addr = (poke && c == 4) ? 13'd7 : b;
      out_ready = (mode == 0) ? 1'b1 : ((c % 4) == 1 || (c % 4) == 0);
      #1;
      if (stall_prev && (out_valid !== 1'b1 || out_data !== sd || out_is_odd !== so || out_last !== sl))
        hold_err++;
      if ((rEn_even_AH != '0 && rEn_even_AH != '1) || (rEn_odd_AH != '0 && rEn_odd_AH != '1) ||
          (rEn_even_AH[0] && rEn_odd_AH[0])) en_err++;
      for (int r = 1; r < NR; r++)
        if (rAddr_even[r] !== rAddr_even[0] || rAddr_odd[r] !== rAddr_odd[0]) en_err++;
      if ((rEn_even_AH[0] || rEn_odd_AH[0]) && nr < 64) begin
        rodd[nr] = rEn_odd_AH[0];
        raddr[nr] = rEn_odd_AH[0] ? rAddr_odd[0] : rAddr_even[0];
        rcyc[nr] = c;
        nr++;
      end
      if (out_valid) valid_cnt++;
      stall_prev = out_valid && !out_ready;
      if (stall_prev) begin sd = out_data; so = out_is_odd; sl = out_last; stalls++; end
      if (out_valid && out_ready && nb < 64) begin
        bdata[nb] = out_data; bodd[nb] = out_is_odd; blast[nb] = out_last; bcyc[nb] = c; nb++;
      end
      if (nr - nb > max_out) max_out = nr - nb;
      if (done) begin done_cyc = c; busy_at_done = busy; break; end
      if (stop_at > 0 && nb == stop_at) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({busy, done, out_valid, out_is_odd, out_last} !== 5'b0) begin bad++;
      $display("FAIL reset_ctl got=%b exp=00000", {busy, done, out_valid, out_is_odd, out_last}); end
    total++; if ({rEn_even_AH, rEn_odd_AH} !== '0) begin bad++;
      $display("FAIL reset_en got=%h exp=0", {rEn_even_AH, rEn_odd_AH}); end
    total++; if ({rAddr_even, rAddr_odd} !== '0 || out_data !== '0) begin bad++;
      $display("FAIL reset_data addr=%h data=%h exp=0", {rAddr_even, rAddr_odd}, out_data); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    run_sweep(13'd0, 14'd4, 0, 0, 0);
    total++; if (nr !== 8 || nb !== 8) begin bad++; $display("FAIL basic_count reads=%0d beats=%0d exp=8/8", nr, nb); end
    for (int i = 0; i < 8; i++) begin
      total++; if (rcyc[i] !== i + 1 || rodd[i] !== 1'(i % 2) || raddr[i] !== 13'(i / 2)) begin bad++;
        $display("FAIL basic_read%0d cyc=%0d odd=%0d addr=%0d exp %0d/%0d/%0d", i, rcyc[i], rodd[i], raddr[i], i + 1, i % 2, i / 2); end
      total++; if (bdata[i] !== exp_vec(1'(i % 2), 13'(i / 2)) || bodd[i] !== 1'(i % 2) ||
                   blast[i] !== (i == 7) || bcyc[i] !== i + 3) begin bad++;
        $display("FAIL basic_beat%0d cyc=%0d odd=%0d last=%0d data=%h exp cyc=%0d data=%h", i, bcyc[i], bodd[i], blast[i], bdata[i], i + 3, exp_vec(1'(i % 2), 13'(i / 2))); end
    end
    total++; if (done_cyc !== 11 || busy_at_done !== 1'b0) begin bad++;
      $display("FAIL basic_done cyc=%0d busy=%b exp 11/0", done_cyc, busy_at_done); end
    total++; if (en_err !== 0) begin bad++; $display("FAIL basic_enables errors=%0d exp=0", en_err); end
  endtask

  task automatic test_wrap();
    run_sweep(13'd8190, 14'd4, 0, 0, 0);
    total++; if (nr !== 8 || nb !== 8 || done_cyc !== 11) begin bad++;
      $display("FAIL wrap_count reads=%0d beats=%0d done=%0d exp 8/8/11", nr, nb, done_cyc); end
    for (int i = 0; i < 8; i++) begin
      total++; if (raddr[i] !== 13'(8190 + i / 2) || bdata[i] !== exp_vec(1'(i % 2), 13'(8190 + i / 2)) ||
                   blast[i] !== (i == 7)) begin bad++;
        $display("FAIL wrap_beat%0d addr=%0d data=%h exp addr=%0d data=%h", i, raddr[i], bdata[i], 13'(8190 + i / 2), exp_vec(1'(i % 2), 13'(8190 + i / 2))); end
    end
  endtask

  task automatic test_backpressure();
    int err;
    run_sweep(13'd100, 14'd4, 1, 0, 1);
    err = 0;
    for (int i = 0; i < 8; i++)
      if (bdata[i] !== exp_vec(1'(i % 2), 13'(100 + i / 2)) || bodd[i] !== 1'(i % 2) || blast[i] !== (i == 7)) err++;
    total++; if (nb !== 8 || nr !== 8 || err !== 0) begin bad++;
      $display("FAIL bp_beats beats=%0d reads=%0d bad_beats=%0d exp 8/8/0", nb, nr, err); end
    total++; if (max_out > 2) begin bad++; $display("FAIL bp_outstanding got=%0d exp<=2", max_out); end
    total++; if (hold_err !== 0 || stalls == 0) begin bad++;
      $display("FAIL bp_hold changes=%0d stalls=%0d exp 0/>0", hold_err, stalls); end
    total++; if (done_cyc < 0 || busy_at_done !== 1'b0) begin bad++;
      $display("FAIL bp_done cyc=%0d busy=%b exp done seen", done_cyc, busy_at_done); end
  endtask

  task automatic test_zero();
    run_sweep(13'd3, 14'd0, 0, 0, 0);
    total++; if (done_cyc !== 1 || busy_at_done !== 1'b0) begin bad++;
      $display("FAIL zero_done cyc=%0d busy=%b exp 1/0", done_cyc, busy_at_done); end
    total++; if (nr !== 0 || valid_cnt !== 0) begin bad++;
      $display("FAIL zero_activity reads=%0d valid=%0d exp 0/0", nr, valid_cnt); end
  endtask

  task automatic test_reset_mid();
    int err, dn;
    run_sweep(13'd5, 14'd16, 0, 3, 0);
    total++; if (nb !== 3) begin bad++; $display("FAIL rstmid_pre beats=%0d exp=3", nb); end
    rst = 1'b1; #1;
    total++; if ({busy, done, out_valid, out_is_odd, out_last} !== 5'b0 || {rEn_even_AH, rEn_odd_AH} !== '0 ||
                 {rAddr_even, rAddr_odd} !== '0 || out_data !== '0) begin bad++;
      $display("FAIL rstmid_outputs ctl=%b en=%h data=%h exp all 0", {busy, done, out_valid, out_is_odd, out_last}, {rEn_even_AH, rEn_odd_AH}, out_data); end
    @(negedge clk); rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); #1; if (done || busy || out_valid) dn++; end
    total++; if (dn !== 0) begin bad++; $display("FAIL rstmid_quiet active_cycles=%0d exp=0", dn); end
    run_sweep(13'd20, 14'd16, 0, 0, 0);
    err = 0;
    for (int i = 0; i < 32; i++)
      if (bdata[i] !== exp_vec(1'(i % 2), 13'(20 + i / 2)) || bodd[i] !== 1'(i % 2) || blast[i] !== (i == 31)) err++;
    total++; if (nb !== 32 || err !== 0 || done_cyc !== 35) begin bad++;
      $display("FAIL rstmid_resweep beats=%0d bad_beats=%0d done=%0d exp 32/0/35", nb, err, done_cyc); end
  endtask

  task automatic test_relu();
    row_t e0, e1;
    for (int r = 0; r < NR; r++) begin
`ifdef OUTDRAIN_RELU_EN
      e0[r] = 16'h0000;
`else
      e0[r] = 16'hFF00;
`endif
      e1[r] = 16'h0100;
    end
    pat = 1;
    run_sweep(13'd0, 14'd1, 0, 0, 0);
    pat = 0;
    total++; if (nb !== 2 || bdata[0] !== e0) begin bad++;
      $display("FAIL relu_neg beats=%0d data=%h exp=%h", nb, bdata[0], e0); end
    total++; if (bdata[1] !== e1 || blast[1] !== 1'b1) begin bad++;
      $display("FAIL relu_pos data=%h last=%b exp=%h/1", bdata[1], blast[1], e1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_relu();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/outbuff_drain_ctrl.md
Name: outbuff_drain_ctrl

Overview:
Read-side controller for the double (even/odd) output buffer banks. On a start command it sweeps a programmable address range and issues active-high read enables and addresses to all rows of both banks. It captures the 1-cycle-latency SRAM read data and streams each row vector downstream over a valid/ready interface, in even/odd interleaved order. It replaces the dummy read control used in power runs with a real drain path toward the result writeback.

Parameters:
num_pe_row, 16, rows per bank; width of the enable vectors and row count of the data vector
data_width_to_buff, 16, bits per stored word
nb_data, 8192, words per bank
addr_width, clogb2(nb_data) = 13, address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  begin a sweep; sampled only in IDLE
base_addr  in  addr_width  first address, latched on start
num_words  in  addr_width+1  addresses to sweep per bank, range 0..nb_data
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the sweep completes
rEn_even_AH  out  num_pe_row  read enable for the even bank, all bits identical
rEn_odd_AH  out  num_pe_row  read enable for the odd bank, all bits identical
rAddr_even  out  num_pe_row x addr_width  even-bank read address, broadcast to all rows
rAddr_odd  out  num_pe_row x addr_width  odd-bank read address, broadcast to all rows
buff_data_out_even  in  num_pe_row x data_width_to_buff  even-bank read data, valid 1 cycle after enable
buff_data_out_odd  in  num_pe_row x data_width_to_buff  odd-bank read data
out_data  out  num_pe_row x data_width_to_buff  streamed row vector
out_is_odd  out  1  beat came from the odd bank
out_last  out  1  final beat of the sweep
out_valid  out  1  beat available
out_ready  in  1  downstream accepts the beat

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; FIFO empty; no read in flight.
- FSM states: IDLE, READ, FLUSH, DONE.
- IDLE: on start with num_words=0, go to DONE with no reads. On start with num_words>0, latch base_addr and num_words, set busy, go to READ.
- Read order: even@a, odd@a, even@a+1, odd@a+1, and so on. a runs from base_addr for num_words addresses. Address arithmetic is mod 2^addr_width, so a sweep wraps through 0.
- Each read asserts exactly one bank's enable vector for one cycle. The addresses hold their last value when no read is issued.
- Output buffering: 2-entry FIFO. A read issues in a cycle only when FIFO occupancy plus reads in flight (0 or 1) is less than 2.
- With out_ready held high, one read issues per cycle and out_valid stays continuously high after a 2-cycle startup: read in cycle N, data captured at the end of N+1, visible on out_data in N+2.
- Read data is captured into the FIFO exactly 1 cycle after its enable, tagged with the bank and a last flag.
- READ to FLUSH when the odd read of the final address has issued. FLUSH to DONE when the FIFO is empty and nothing is in flight.
- DONE lasts one cycle: done=1, busy drops to 0 in the same cycle, then return to IDLE.
- out_valid/out_data/out_is_odd/out_last hold stable while out_valid=1 and out_ready=0. A beat transfers when out_valid and out_ready are both high.
- Exactly 2*num_words beats per sweep; out_last is set only on the odd beat of the final address.
- start while busy is ignored.
- rst asserted mid-sweep: immediate return to reset state, FIFO flushed, in-flight data discarded, no done pulse.

Optional Feature:
OUTDRAIN_RELU_EN
- Defined: each word is treated as signed two's complement. Negative words are replaced by 0 on out_data; non-negative words pass unchanged. Clamping is combinational at the FIFO output and adds no latency.
- Undefined: words pass through unmodified.

Test Plan:
- base_addr=0, num_words=4, out_ready=1 -> enables alternate even/odd for 8 cycles with addresses 0,0,1,1,2,2,3,3; 8 beats in order; out_last on beat 8 only; done one cycle after the last beat transfers.
- base_addr=8190, num_words=4 -> addresses 8190, 8191, 0, 1 (wrap); 8 beats with correct data.
- num_words=4, out_ready toggling 1,0,0,1 -> no more than 2 reads outstanding; no beat lost or duplicated; data stable while stalled.
- num_words=0 -> done pulse 1 cycle after start, no enable ever asserted, out_valid stays 0.
- rst pulsed after 3 beats of a 16-word sweep -> all outputs 0 immediately, no done; a fresh start afterwards runs a full correct sweep.
- OUTDRAIN_RELU_EN defined, bank word 16'hFF00 -> out_data word 0; word 16'h0100 -> 16'h0100. Undefined: 16'hFF00 passes through as 16'hFF00.
